// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational operand forwarding, a one-cycle
// load-use stall, and a small FSM that stalls the front end for a multi-cycle multiply.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_is_mul,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fw_a,
  output logic [1:0]            fw_b,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  mul_busy,
  output logic [31:0]           stall_cycles
);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

  state_t     state;
  logic [3:0] mul_cnt;
  logic       mul_start;
  logic       mul_stall;
  logic       load_use;

  // EX/MEM result is newer than the writeback value, so it is checked first.
  always_comb begin
    fw_a = 2'b00;
    if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1)
      fw_a = 2'b10;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1)
      fw_a = 2'b01;

    fw_b = 2'b00;
    if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2)
      fw_b = 2'b10;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2)
      fw_b = 2'b01;
  end

  always_comb begin
    mul_start = ex_valid && ex_is_mul && (state == IDLE);
    mul_stall = mul_start || (state == MUL_BUSY && mul_cnt != 4'd0);
    load_use  = (state == IDLE) && !mul_start && id_valid && ex_valid &&
                ex_memread && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (mul_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // The release cycle (count at zero) returns to IDLE while the multiply
  // leaves EX, so it cannot immediately retrigger itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mul_cnt      <= 4'd0;
      mul_busy     <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state    <= MUL_BUSY;
            mul_cnt  <= MUL_CNT_INIT;
            mul_busy <= 1'b1;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
          end else begin
            state    <= IDLE;
            mul_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          mul_busy <= 1'b0;
        end
      endcase
      if (!pc_write && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int AW      = 5;
  localparam int MUL_LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, ex_valid, ex_memread, ex_is_mul, mem_regwrite, wb_regwrite;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0]    fw_a, fw_b;
  logic          pc_write, ifid_write, idex_write, idex_flush, exmem_flush, mul_busy;
  logic [31:0]   stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Model: cycles the current multiply still spends in EX (0 = none), stall count.
  int          m_left;
  logic [31:0] m_cnt;

  hazard_ctrl #(.REG_ADDR_W(AW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_is_mul(ex_is_mul),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .fw_a(fw_a), .fw_b(fw_b),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mul_busy(mul_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic rs_ok, input logic [AW-1:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return rs_ok ? 2'b00 : 2'b00;
  endfunction

  task automatic clear_inputs();
    id_valid = 0; ex_valid = 0; ex_memread = 0; ex_is_mul = 0;
    mem_regwrite = 0; wb_regwrite = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  // Compare every output with the model for the current inputs, advance the
  // model as the clock edge will, and return at the next falling edge.
  task automatic cycle();
    logic starting, mstall, luse;
    logic [4:0] exp_ctl;
    #1;
    starting = (m_left == 0) && ex_valid && ex_is_mul;
    mstall   = starting || (m_left > 1);
    luse     = (m_left == 0) && !starting && id_valid && ex_valid && ex_memread &&
               ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (mstall)     exp_ctl = 5'b000_01;
    else if (luse)  exp_ctl = 5'b001_10;
    else            exp_ctl = 5'b111_00;
    check("fw_a", 32'(fw_a), 32'(fwd_sel(1'b1, ex_rs1)));
    check("fw_b", 32'(fw_b), 32'(fwd_sel(1'b1, ex_rs2)));
    check("ctl{pc,ifid,idex,idflush,exflush}",
          32'({pc_write, ifid_write, idex_write, idex_flush, exmem_flush}), 32'(exp_ctl));
    check("mul_busy", 32'(mul_busy), 32'(m_left > 0));
    check("stall_cycles", stall_cycles, m_cnt);
    if (rst) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if (starting)        m_left = MUL_LAT - 1;
      else if (m_left > 0) m_left = m_left - 1;
      if ((mstall || luse) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    logic [3:0]  pc_seq, busy_seq;

    clear_inputs();
    rst = 1;
    m_left = 0;
    m_cnt  = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_mul_busy", 32'(mul_busy), 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    rst = 0;
    @(negedge clk);

    // Forwarding priority and register-0 exclusion
    ex_rs1 = 5; mem_regwrite = 1; mem_rd = 5; wb_regwrite = 1; wb_rd = 5;
    #1 check("fw_both_match", 32'(fw_a), 32'd2);
    cycle();
    mem_regwrite = 0;
    #1 check("fw_wb_only", 32'(fw_a), 32'd1);
    cycle();
    ex_rs1 = 0; mem_regwrite = 1; mem_rd = 0; wb_rd = 0;
    #1 check("fw_reg0", 32'(fw_a), 32'd0);
    cycle();

    // Load-use: one-cycle bubble
    clear_inputs();
    base = m_cnt;
    id_valid = 1; ex_valid = 1; ex_memread = 1; ex_rd = 7; id_rs2 = 7;
    #1 check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_idex_flush", 32'(idex_flush), 32'd1);
    cycle();
    clear_inputs();
    #1 check("lu_stall_count", stall_cycles, base + 32'd1);
    check("lu_released", 32'(pc_write), 32'd1);
    cycle();

    // Multiply held in EX: three stall cycles then release
    base = m_cnt;
    ex_valid = 1; ex_is_mul = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      pc_seq[i]   = pc_write;
      busy_seq[i] = mul_busy;
      cycle();
    end
    clear_inputs();
    check("mul_pc_seq", 32'(pc_seq), 32'b1000);
    check("mul_busy_seq", 32'(busy_seq), 32'b1110);
    #1 check("mul_stall_count", stall_cycles, base + 32'd3);
    cycle();

    // Multiply start coinciding with a load-use condition: multiply wins
    ex_valid = 1; ex_is_mul = 1; ex_memread = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7;
    #1 check("simul_idex_flush", 32'(idex_flush), 32'd0);
    check("simul_exmem_flush", 32'(exmem_flush), 32'd1);
    repeat (4) cycle();
    clear_inputs();
    cycle();

    // Reset during the second stall cycle of a multiply
    ex_valid = 1; ex_is_mul = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    clear_inputs();
    #1 check("rst_mid_mul_busy", 32'(mul_busy), 32'd0);
    check("rst_mid_mul_count", stall_cycles, 32'd0);
    check("rst_mid_mul_pc", 32'(pc_write), 32'd1);
    cycle();

    // Saturation of the stall counter
    force dut.stall_cycles = 32'hFFFF_FFFD;
    #1 release dut.stall_cycles;
    m_cnt = 32'hFFFF_FFFD;
    ex_valid = 1; ex_is_mul = 1;
    repeat (4) cycle();
    clear_inputs();
    #1 check("saturate", stall_cycles, 32'hFFFF_FFFF);
    cycle();
    ex_valid = 1; ex_memread = 1; ex_rd = 3; id_valid = 1; id_rs1 = 3;
    cycle();
    clear_inputs();
    #1 check("saturate_hold", stall_cycles, 32'hFFFF_FFFF);
    cycle();

    // Randomized traffic with small register indices to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      id_valid     = 1'($urandom_range(0, 3) != 0);
      ex_valid     = 1'($urandom_range(0, 3) != 0);
      ex_memread   = 1'($urandom_range(0, 2) == 0);
      ex_is_mul    = 1'($urandom_range(0, 4) == 0);
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite  = 1'($urandom_range(0, 1));
      id_rs1 = AW'($urandom_range(0, 7));
      id_rs2 = AW'($urandom_range(0, 7));
      ex_rs1 = AW'($urandom_range(0, 7));
      ex_rs2 = AW'($urandom_range(0, 7));
      ex_rd  = AW'($urandom_range(0, 7));
      mem_rd = AW'($urandom_range(0, 7));
      wb_rd  = AW'($urandom_range(0, 7));
      cycle();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
